// File: rtl/five_stage_hazard_detection_unit.sv
// Hazard detection for a 5-stage core: load-use, data/instr memory, redirects.
// Ports: clock, async active-low reset, decode/execute/memory status in;
// seven 1-bit stall-request outputs; optional 32-bit stat_* counters out.
// Macro FIVE_STAGE_HAZARD_STATS_EN adds the statistics counters and ports.
module five_stage_hazard_detection_unit #(
  parameter int CORE               = 0,
  parameter int MAX_FETCH_INFLIGHT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  decode_rs1,
  input  logic [4:0]  decode_rs2,
  input  logic [1:0]  decode_rs_used,
  input  logic [4:0]  execute_rd,
  input  logic        execute_load,
  input  logic        d_mem_req_valid,
  input  logic        d_mem_req_ready,
  input  logic        d_mem_resp_valid,
  input  logic        i_mem_req_fire,
  input  logic        i_mem_resp_valid,
  input  logic        execute_redirect,
  input  logic        decode_jal,
`ifdef FIVE_STAGE_HAZARD_STATS_EN
  output logic [31:0] stat_data_stalls,
  output logic [31:0] stat_dmem_stalls,
  output logic [31:0] stat_imem_stalls,
  output logic [31:0] stat_flushes,
`endif
  output logic        true_data_hazard,
  output logic        d_mem_issue_hazard,
  output logic        d_mem_recv_hazard,
  output logic        i_mem_hazard,
  output logic        JALR_branch_hazard,
  output logic        JAL_hazard,
  output logic        i_mem_drop
);

  if (MAX_FETCH_INFLIGHT < 1 || MAX_FETCH_INFLIGHT > 7 || CORE < 0) begin : g_bad_cfg
    $error("illegal parameters");
  end

  localparam logic [2:0] LP_MAX = 3'(MAX_FETCH_INFLIGHT);

  typedef enum logic {
    D_IDLE = 1'b0,
    D_WAIT = 1'b1
  } dmem_state_e;

  dmem_state_e r_dstate;
  dmem_state_e w_dstate_nxt;

  logic [2:0] r_inflight;
  logic [2:0] w_inflight_nxt;
  logic [2:0] r_stale;
  logic [2:0] w_stale_nxt;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_data_hz;
  logic w_accept;
  logic w_issue_hz;
  logic w_recv_hz;
  logic w_drop;
  logic w_imem_hz;
  logic w_jalr_hz;
  logic w_jal_hz;
  logic w_flush;

  assign w_rs1_hit = decode_rs_used[0] & (decode_rs1 == execute_rd);
  assign w_rs2_hit = decode_rs_used[1] & (decode_rs2 == execute_rd);
  assign w_data_hz = execute_load & (execute_rd != 5'd0)
                   & (w_rs1_hit | w_rs2_hit);

  // A new request may overlap the response that retires the old one.
  assign w_accept = d_mem_req_valid & d_mem_req_ready
                  & ((r_dstate == D_IDLE) | d_mem_resp_valid);
  assign w_issue_hz = d_mem_req_valid & ~w_accept;
  assign w_recv_hz  = (r_dstate == D_WAIT) & ~d_mem_resp_valid;

  always_comb begin
    w_dstate_nxt = r_dstate;
    unique case (r_dstate)
      D_IDLE: if (w_accept) w_dstate_nxt = D_WAIT;
      D_WAIT: if (d_mem_resp_valid && !w_accept) w_dstate_nxt = D_IDLE;
      default: w_dstate_nxt = D_IDLE;
    endcase
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (i_mem_req_fire && i_mem_resp_valid) begin
      w_inflight_nxt = r_inflight;
    end else if (i_mem_req_fire) begin
      if (r_inflight < LP_MAX) w_inflight_nxt = r_inflight + 3'd1;
    end else if (i_mem_resp_valid) begin
      if (r_inflight != 3'd0) w_inflight_nxt = r_inflight - 3'd1;
    end
  end

  assign w_jalr_hz = execute_redirect;
  assign w_jal_hz  = decode_jal & ~execute_redirect;
  assign w_flush   = w_jalr_hz | w_jal_hz;
  assign w_drop    = (r_stale != 3'd0) & i_mem_resp_valid;
  assign w_imem_hz = ((r_inflight != 3'd0) & ~i_mem_resp_valid) | w_drop;

  // Fetches still in flight at a redirect return wrong-path data; the
  // response arriving this very cycle is already consumed, so exclude it.
  always_comb begin
    w_stale_nxt = r_stale;
    if (w_flush) begin
      if (r_inflight != 3'd0)
        w_stale_nxt = r_inflight - {2'b00, i_mem_resp_valid};
      else
        w_stale_nxt = 3'd0;
    end else if (w_drop) begin
      w_stale_nxt = r_stale - 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dstate   <= D_IDLE;
      r_inflight <= 3'd0;
      r_stale    <= 3'd0;
    end else begin
      r_dstate   <= w_dstate_nxt;
      r_inflight <= w_inflight_nxt;
      r_stale    <= w_stale_nxt;
    end
  end

  // Outputs are forced low during reset so the stall unit sees no stalls.
  assign true_data_hazard   = reset & w_data_hz;
  assign d_mem_issue_hazard = reset & w_issue_hz;
  assign d_mem_recv_hazard  = reset & w_recv_hz;
  assign i_mem_hazard       = reset & w_imem_hz;
  assign JALR_branch_hazard = reset & w_jalr_hz;
  assign JAL_hazard         = reset & w_jal_hz;
  assign i_mem_drop         = reset & w_drop;

`ifdef FIVE_STAGE_HAZARD_STATS_EN
  logic [31:0] r_st_data;
  logic [31:0] r_st_dmem;
  logic [31:0] r_st_imem;
  logic [31:0] r_st_flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st_data  <= 32'd0;
      r_st_dmem  <= 32'd0;
      r_st_imem  <= 32'd0;
      r_st_flush <= 32'd0;
    end else begin
      if (w_data_hz && r_st_data != 32'hFFFF_FFFF)
        r_st_data <= r_st_data + 32'd1;
      if ((w_issue_hz || w_recv_hz) && r_st_dmem != 32'hFFFF_FFFF)
        r_st_dmem <= r_st_dmem + 32'd1;
      if (w_imem_hz && r_st_imem != 32'hFFFF_FFFF)
        r_st_imem <= r_st_imem + 32'd1;
      if (w_flush && r_st_flush != 32'hFFFF_FFFF)
        r_st_flush <= r_st_flush + 32'd1;
    end
  end

  assign stat_data_stalls = r_st_data;
  assign stat_dmem_stalls = r_st_dmem;
  assign stat_imem_stalls = r_st_imem;
  assign stat_flushes     = r_st_flush;
`endif

endmodule

// File: tb/tb_five_stage_hazard_detection_unit.sv
// Bench for five_stage_hazard_detection_unit.
// Expected output vectors queue up at drive time, compared at sample time.
module tb_five_stage_hazard_detection_unit;

  localparam int MAXF = 2;

  logic       clock;
  logic       reset;
  logic [4:0] decode_rs1;
  logic [4:0] decode_rs2;
  logic [1:0] decode_rs_used;
  logic [4:0] execute_rd;
  logic       execute_load;
  logic       d_mem_req_valid;
  logic       d_mem_req_ready;
  logic       d_mem_resp_valid;
  logic       i_mem_req_fire;
  logic       i_mem_resp_valid;
  logic       execute_redirect;
  logic       decode_jal;
  logic       true_data_hazard;
  logic       d_mem_issue_hazard;
  logic       d_mem_recv_hazard;
  logic       i_mem_hazard;
  logic       JALR_branch_hazard;
  logic       JAL_hazard;
  logic       i_mem_drop;
`ifdef FIVE_STAGE_HAZARD_STATS_EN
  logic [31:0] stat_data_stalls;
  logic [31:0] stat_dmem_stalls;
  logic [31:0] stat_imem_stalls;
  logic [31:0] stat_flushes;
  int unsigned m_sd, m_sm, m_si, m_sf;
`endif

  five_stage_hazard_detection_unit #(
    .CORE(0),
    .MAX_FETCH_INFLIGHT(MAXF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .decode_rs1(decode_rs1),
    .decode_rs2(decode_rs2),
    .decode_rs_used(decode_rs_used),
    .execute_rd(execute_rd),
    .execute_load(execute_load),
    .d_mem_req_valid(d_mem_req_valid),
    .d_mem_req_ready(d_mem_req_ready),
    .d_mem_resp_valid(d_mem_resp_valid),
    .i_mem_req_fire(i_mem_req_fire),
    .i_mem_resp_valid(i_mem_resp_valid),
    .execute_redirect(execute_redirect),
    .decode_jal(decode_jal),
`ifdef FIVE_STAGE_HAZARD_STATS_EN
    .stat_data_stalls(stat_data_stalls),
    .stat_dmem_stalls(stat_dmem_stalls),
    .stat_imem_stalls(stat_imem_stalls),
    .stat_flushes(stat_flushes),
`endif
    .true_data_hazard(true_data_hazard),
    .d_mem_issue_hazard(d_mem_issue_hazard),
    .d_mem_recv_hazard(d_mem_recv_hazard),
    .i_mem_hazard(i_mem_hazard),
    .JALR_branch_hazard(JALR_branch_hazard),
    .JAL_hazard(JAL_hazard),
    .i_mem_drop(i_mem_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk;
  int n_fail;
  logic [6:0] exp_q[$];

  // model state
  bit m_wait;
  int m_inf;
  int m_stale;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] model_out();
    bit tdh, acc, iss, recv, drop, imh, jr, jl;
    if (!reset) return 7'd0;
    tdh = execute_load && execute_rd != 0 &&
          ((decode_rs_used[0] && decode_rs1 == execute_rd) ||
           (decode_rs_used[1] && decode_rs2 == execute_rd));
    acc = d_mem_req_valid && d_mem_req_ready &&
          (!m_wait || d_mem_resp_valid);
    iss = d_mem_req_valid && !acc;
    recv = m_wait && !d_mem_resp_valid;
    drop = m_stale != 0 && i_mem_resp_valid;
    imh = (m_inf != 0 && !i_mem_resp_valid) || drop;
    jr = execute_redirect;
    jl = decode_jal && !execute_redirect;
    return {tdh, iss, recv, imh, jr, jl, drop};
  endfunction

  task automatic model_update(input logic [6:0] o);
    bit acc;
    if (!reset) begin
      m_wait = 0; m_inf = 0; m_stale = 0;
`ifdef FIVE_STAGE_HAZARD_STATS_EN
      m_sd = 0; m_sm = 0; m_si = 0; m_sf = 0;
`endif
      return;
    end
`ifdef FIVE_STAGE_HAZARD_STATS_EN
    m_sd += o[6]; m_sm += (o[5] | o[4]); m_si += o[3];
    m_sf += (o[2] | o[1]);
`endif
    acc = d_mem_req_valid && d_mem_req_ready &&
          (!m_wait || d_mem_resp_valid);
    if (execute_redirect || decode_jal)
      m_stale = (m_inf == 0) ? 0 : m_inf - int'(i_mem_resp_valid);
    else if (o[0])
      m_stale--;
    if (i_mem_req_fire && !i_mem_resp_valid && m_inf < MAXF) m_inf++;
    else if (!i_mem_req_fire && i_mem_resp_valid && m_inf > 0) m_inf--;
    if (!m_wait) m_wait = acc;
    else if (d_mem_resp_valid) m_wait = acc;
  endtask

  task automatic step(input string tag);
    logic [6:0] e;
    logic [6:0] g;
    e = model_out();
    exp_q.push_back(e);
    #1;
    g = {true_data_hazard, d_mem_issue_hazard, d_mem_recv_hazard,
         i_mem_hazard, JALR_branch_hazard, JAL_hazard, i_mem_drop};
    check(tag, 32'(g), 32'(exp_q.pop_front()));
    @(posedge clock);
    model_update(e);
    @(negedge clock);
  endtask

  task automatic idle_in();
    decode_rs1 = 0; decode_rs2 = 0; decode_rs_used = 0;
    execute_rd = 0; execute_load = 0;
    d_mem_req_valid = 0; d_mem_req_ready = 0; d_mem_resp_valid = 0;
    i_mem_req_fire = 0; i_mem_resp_valid = 0;
    execute_redirect = 0; decode_jal = 0;
  endtask

  task automatic rand_in();
    decode_rs1 = 5'($urandom_range(0, 3));
    decode_rs2 = 5'($urandom_range(0, 3));
    decode_rs_used = 2'($urandom);
    execute_rd = 5'($urandom_range(0, 3));
    execute_load = 1'($urandom);
    d_mem_req_valid = 1'($urandom);
    d_mem_req_ready = 1'($urandom);
    d_mem_resp_valid = 1'($urandom);
    i_mem_req_fire = 1'($urandom);
    i_mem_resp_valid = 1'($urandom);
    execute_redirect = ($urandom_range(0, 7) == 0);
    decode_jal = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m_wait = 0; m_inf = 0; m_stale = 0;
    reset = 1'b0;
    idle_in();
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rand_in();
      execute_redirect = 1;
      step("reset_outs");
    end
    reset = 1'b1;
    idle_in();
    step("cold_idle");

    // load-use
    execute_load = 1; execute_rd = 5; decode_rs1 = 5; decode_rs_used = 2'b01;
    step("ld_use_rs1");
    execute_rd = 0; decode_rs1 = 0;
    step("ld_rd0");
    execute_rd = 7; decode_rs1 = 7; decode_rs_used = 2'b10;
    step("ld_rs1_unused");
    decode_rs2 = 7;
    step("ld_use_rs2");
    execute_load = 0;
    step("no_load");
    idle_in();

    // issue stall then accept, wait for response
    d_mem_req_valid = 1;
    step("issue_stall0");
    step("issue_stall1");
    d_mem_req_ready = 1;
    step("issue_accept");
    idle_in();
    step("recv_wait0");
    step("recv_wait1");
    // response plus back-to-back accept
    d_mem_resp_valid = 1; d_mem_req_valid = 1; d_mem_req_ready = 1;
    step("resp_and_accept");
    idle_in();
    step("still_wait");
    d_mem_resp_valid = 1;
    step("resp_done");
    idle_in();
    step("dmem_idle");

    // stale fetch drops
    i_mem_req_fire = 1;
    step("fire0");
    step("fire1");
    step("fire_sat");
    i_mem_req_fire = 0; execute_redirect = 1;
    step("redirect");
    execute_redirect = 0; i_mem_resp_valid = 1;
    step("drop0");
    step("drop1");
    step("drop_end");
    i_mem_resp_valid = 0;
    step("imem_empty");

    // jal vs redirect priority
    execute_redirect = 1; decode_jal = 1;
    step("jalr_over_jal");
    execute_redirect = 0;
    step("jal_only");
    idle_in();
    step("flush_idle");

    // reset mid-transaction
    d_mem_req_valid = 1; d_mem_req_ready = 1; i_mem_req_fire = 1;
    step("pre_rst_acc");
    d_mem_req_valid = 0; d_mem_req_ready = 0;
    step("pre_rst_fire");
    execute_load = 1; execute_rd = 3; decode_rs1 = 3; decode_rs_used = 1;
    d_mem_req_valid = 1; decode_jal = 1;
    reset = 1'b0;
    #1;
    check("async_rst_out",
          32'({true_data_hazard, d_mem_issue_hazard, d_mem_recv_hazard,
               i_mem_hazard, JALR_branch_hazard, JAL_hazard, i_mem_drop}),
          32'd0);
    step("in_reset");
    reset = 1'b1;
    idle_in();
    step("post_rst_cold");
    d_mem_req_valid = 1; d_mem_req_ready = 1;
    step("post_rst_acc");
    idle_in();

    for (int i = 0; i < 300; i++) begin
      rand_in();
      step("random");
    end
    idle_in();
    step("final_idle");

`ifdef FIVE_STAGE_HAZARD_STATS_EN
    #1;
    check("stat_data", stat_data_stalls, m_sd);
    check("stat_dmem", stat_dmem_stalls, m_sm);
    check("stat_imem", stat_imem_stalls, m_si);
    check("stat_flush", stat_flushes, m_sf);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/five_stage_hazard_detection_unit.md
FIVE_STAGE_HAZARD_DETECTION_UNIT -- requirements
Module: five_stage_hazard_detection_unit

Interface
REQ-001 Parameter CORE, default 0: core index, carried for debug and scan identification only.
REQ-002 Parameter MAX_FETCH_INFLIGHT, default 2: maximum number of outstanding instruction fetches, legal range 1..7.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-005 decode_rs1 / decode_rs2  input  5 each  source registers of the instruction in decode.
REQ-006 decode_rs_used  input  2  bit0 = rs1 read, bit1 = rs2 read.
REQ-007 execute_rd  input  5 and execute_load  input  1  destination register of the instruction in execute, and a flag that it is a load.
REQ-008 d_mem_req_valid / d_mem_req_ready / d_mem_resp_valid  input  1 each  data-memory request handshake and response strobe.
REQ-009 i_mem_req_fire / i_mem_resp_valid  input  1 each  fetch request accepted, and fetch response present.
REQ-010 execute_redirect  input  1 and decode_jal  input  1  taken branch/JALR resolved in execute, and JAL present in decode.
REQ-011 Outputs, 1 bit each: true_data_hazard, d_mem_issue_hazard, d_mem_recv_hazard, i_mem_hazard, JALR_branch_hazard, JAL_hazard, i_mem_drop; these feed the stall unit.

Function
REQ-012 true_data_hazard = execute_load & (execute_rd != 0) & ((decode_rs_used[0] & rs1 == execute_rd) | (decode_rs_used[1] & rs2 == execute_rd)); combinational.
REQ-013 Data-memory FSM, states D_IDLE and D_WAIT.
- D_IDLE -> D_WAIT when req_valid & req_ready.
- D_WAIT -> D_IDLE on resp_valid with no new accept.
- D_WAIT stays in D_WAIT on resp_valid plus a same-cycle accept.
REQ-014 A request is accepted only when req_valid & req_ready & (D_IDLE | resp_valid).
REQ-015 d_mem_issue_hazard = req_valid & not accepted, in the same cycle.
REQ-016 d_mem_recv_hazard = D_WAIT & ~resp_valid.
REQ-017 Fetch counter inflight, 3 bits, updated as follows:
- +1 on req_fire; -1 on resp_valid; unchanged when both occur.
- Fire at MAX_FETCH_INFLIGHT is ignored; the counter saturates.
- resp_valid at 0 is ignored; the counter never underflows.
REQ-018 JALR_branch_hazard = execute_redirect.
REQ-019 JAL_hazard = decode_jal & ~execute_redirect.
REQ-020 On JALR_branch_hazard or JAL_hazard, the stale counter loads (inflight - resp_valid) at the next edge; the redirect reload wins over the stale-counter decrement.
REQ-021 i_mem_drop = (stale != 0) & resp_valid; each dropped response decrements stale.
REQ-022 i_mem_hazard = ((inflight != 0) & ~resp_valid) | i_mem_drop.
REQ-023 Latency: every hazard output is combinational from the current inputs and state; there is zero added cycle of delay.

Reset
REQ-024 While reset = 0, every output is 0 regardless of the inputs.
REQ-025 Reset clears the FSM to D_IDLE and clears inflight, stale and all statistics counters to 0.
REQ-026 Reset mid-transaction discards outstanding requests; the first cycle after release behaves as a cold start.

Configuration
REQ-027 Macro FIVE_STAGE_HAZARD_STATS_EN, when defined, adds four 32-bit outputs:
- stat_data_stalls: cycles with true_data_hazard.
- stat_dmem_stalls: cycles with either d_mem hazard.
- stat_imem_stalls: cycles with i_mem_hazard.
- stat_flushes: cycles with either redirect.
Each counter saturates at 0xFFFFFFFF.
REQ-028 When the macro is undefined, the statistics ports and logic are absent and all other behaviour is identical.

Verification
REQ-029 execute_load=1, execute_rd=5, decode_rs1=5, rs_used=01 -> true_data_hazard=1; execute_rd=0 with the same inputs -> 0.
REQ-030 req_valid=1, ready=0 for 2 cycles, then ready=1 -> issue_hazard high for 2 cycles; state D_WAIT next; recv_hazard high until resp_valid.
REQ-031 In D_WAIT, resp_valid and a new accept in the same cycle -> stays in D_WAIT, issue_hazard=0, recv_hazard=0 that cycle.
REQ-032 Two fetch fires, then execute_redirect=1 with no response -> stale=2; the next two responses give i_mem_drop=1, the third gives drop=0.
REQ-033 execute_redirect=1 and decode_jal=1 together -> JALR_branch_hazard=1, JAL_hazard=0.
REQ-034 Reset asserted mid-D_WAIT with inflight=2 -> all outputs 0 immediately; after release, inflight=0, state D_IDLE, i_mem_hazard=0.
